// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// per-stage instruction records and the memory-wait FSM states.
package hazard_pkg;

  localparam int REC_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_EX   = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REC_ADDR_W-1:0] rd;
    logic [REC_ADDR_W-1:0] rs1;
    logic [REC_ADDR_W-1:0] rs2;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_op;
  } stage_rec_t;

  // x0 is hardwired to zero, so a stage never produces a value for it.
  function automatic logic rec_writes(input stage_rec_t r, input logic [REC_ADDR_W-1:0] a);
    return r.valid && r.reg_write && (r.rd == a) && (a != '0);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding source selection for one operand, shared by the EX-side and
// the ID-side (branch comparator) paths.
module fwd_select
  import hazard_pkg::*;
(
  input  stage_rec_t            ex_rec,
  input  stage_rec_t            mem_rec,
  input  stage_rec_t            wb_rec,
  input  logic [REC_ADDR_W-1:0] rs,
  input  logic                  branch_mode,
  output fwd_sel_e              sel
);

  // The ID comparator cannot take a load result from EX or MEM: the data
  // does not exist yet, so those cases are stalls rather than forwards.
  always_comb begin
    sel = FWD_NONE;
    if (branch_mode && rec_writes(ex_rec, rs) && !ex_rec.mem_read) begin
      sel = FWD_EX;
    end else if (rec_writes(mem_rec, rs) && !(branch_mode && mem_rec.mem_read)) begin
      sel = FWD_MEM;
    end else if (rec_writes(wb_rec, rs)) begin
      sel = FWD_WB;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{ex_rec.rs1, ex_rec.rs2, ex_rec.mem_op,
                           mem_rec.rs1, mem_rec.rs2, mem_rec.mem_op,
                           wb_rec.rs1, wb_rec.rs2, wb_rec.mem_read, wb_rec.mem_op};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: forwarding, stalls,
// flush and data-memory freeze. HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_W     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_op,
  input  logic                  id_is_branch,
  input  logic                  pc_redirect,
  input  logic                  dmem_ready,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [1:0]            forward_branch_a,
  output logic [1:0]            forward_branch_b,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  ex_bubble,
  output logic                  pipe_freeze,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt,
  output hz_state_e             state_dbg
);

  stage_rec_t ex_q, mem_q, wb_q, id_rec;
  hz_state_e  state_q, state_d;
  logic       freeze, stall, hit_ex, hit_mem, redirect;
  fwd_sel_e   fa, fb, fba, fbb;

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rd        = id_rd;
    id_rec.rs1       = id_rs1;
    id_rec.rs2       = id_rs2;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
    id_rec.mem_op    = id_mem_op;
  end

  // Data memory handshake: a load/store sitting in MEM is accepted in the cycle
  // dmem_ready is high; while it is low the whole pipeline holds in place.
  always_comb begin
    freeze  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (mem_q.valid && mem_q.mem_op && !dmem_ready) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) state_d = RUN;
        else            freeze  = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  assign hit_ex  = (id_uses_rs1 && rec_writes(ex_q, id_rs1)) ||
                   (id_uses_rs2 && rec_writes(ex_q, id_rs2));
  assign hit_mem = (id_uses_rs1 && rec_writes(mem_q, id_rs1)) ||
                   (id_uses_rs2 && rec_writes(mem_q, id_rs2));

  // A cycle released from MEM_WAIT advances the pipe, so it must see stalls too.
  assign stall = id_valid && !freeze &&
                 ((ex_q.mem_read && hit_ex) ||
                  (id_is_branch && hit_ex) ||
                  (id_is_branch && mem_q.mem_read && hit_mem));

  // Stalled comparator operands are stale, so a redirect is only trusted when
  // the pipe really advances; reset gating keeps the flush low while in reset.
  assign redirect = reset && pc_redirect && !stall && !freeze;

  always_comb begin
    pc_write    = !freeze && !stall;
    ifid_write  = !freeze && !stall;
    ex_bubble   = stall;
    pipe_freeze = freeze;
    ifid_flush  = redirect;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!freeze) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= stall ? '0 : id_rec;
      end
    end
  end

  fwd_select u_fwd_a  (.ex_rec(ex_q), .mem_rec(mem_q), .wb_rec(wb_q), .rs(ex_q.rs1),
                       .branch_mode(1'b0), .sel(fa));
  fwd_select u_fwd_b  (.ex_rec(ex_q), .mem_rec(mem_q), .wb_rec(wb_q), .rs(ex_q.rs2),
                       .branch_mode(1'b0), .sel(fb));
  fwd_select u_fwd_ba (.ex_rec(ex_q), .mem_rec(mem_q), .wb_rec(wb_q), .rs(id_rs1),
                       .branch_mode(1'b1), .sel(fba));
  fwd_select u_fwd_bb (.ex_rec(ex_q), .mem_rec(mem_q), .wb_rec(wb_q), .rs(id_rs2),
                       .branch_mode(1'b1), .sel(fbb));

  assign forward_a        = fa;
  assign forward_b        = fb;
  assign forward_branch_a = id_is_branch ? fba : FWD_NONE;
  assign forward_branch_b = id_is_branch ? fbb : FWD_NONE;
  assign state_dbg        = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + PERF_W'(1);
      if (redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed program fragments
// followed by random instruction streams against a per-stage reference model.
module tb_pipeline_hazard_ctrl;
  import hazard_pkg::*;

  logic        clock, reset;
  logic        id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read, id_mem_op;
  logic        id_is_branch, pc_redirect, dmem_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [1:0]  forward_a, forward_b, forward_branch_a, forward_branch_b;
  logic        pc_write, ifid_write, ifid_flush, ex_bubble, pipe_freeze;
  logic [31:0] stall_cnt, flush_cnt;
  hz_state_e   state_dbg;

  pipeline_hazard_ctrl #(.REG_ADDR_W(5), .PERF_W(32)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_op(id_mem_op),
    .id_is_branch(id_is_branch), .pc_redirect(pc_redirect), .dmem_ready(dmem_ready),
    .forward_a(forward_a), .forward_b(forward_b), .forward_branch_a(forward_branch_a),
    .forward_branch_b(forward_branch_b), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .ex_bubble(ex_bubble), .pipe_freeze(pipe_freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- stimulus records ----------------
  typedef struct {
    bit v, u1, u2, rw, mr, mo, br, redir, rdy;
    int unsigned rs1, rs2, rd;
  } id_t;

  typedef struct {
    bit v, rw, mr, mo;
    int unsigned rd, rs1, rs2;
  } ins_t;

  int checks = 0;
  int failures = 0;

  id_t  cur;
  ins_t m_ex, m_mem, m_wb;
  ins_t empty_ins;
  bit   m_state;
  int unsigned m_stall, m_flush;
  bit   e_freeze, e_stall, e_flush, e_pc_write;

  function automatic id_t mk(bit v, int unsigned rd, int unsigned rs1, int unsigned rs2,
                             bit u1, bit u2, bit rw, bit mr, bit mo, bit br, bit redir);
    id_t s;
    s.v = v; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
    s.rw = rw; s.mr = mr; s.mo = mo; s.br = br; s.redir = redir; s.rdy = 1'b1;
    return s;
  endfunction

  function automatic id_t nop();                                 return mk(0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic id_t alu(int unsigned d, int unsigned a, int unsigned b); return mk(1,d,a,b,1,1,1,0,0,0,0); endfunction
  function automatic id_t alui(int unsigned d, int unsigned a);  return mk(1,d,a,0,1,0,1,0,0,0,0); endfunction
  function automatic id_t load(int unsigned d, int unsigned a);  return mk(1,d,a,0,1,0,1,1,1,0,0); endfunction
  function automatic id_t store(int unsigned a, int unsigned b); return mk(1,0,a,b,1,1,0,0,1,0,0); endfunction
  function automatic id_t branch(int unsigned a, int unsigned b, bit redir);
    return mk(1,0,a,b,1,1,0,0,0,1,redir);
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input id_t s);
    id_valid     = s.v;
    id_rd        = s.rd[4:0];
    id_rs1       = s.rs1[4:0];
    id_rs2       = s.rs2[4:0];
    id_uses_rs1  = s.u1;
    id_uses_rs2  = s.u2;
    id_reg_write = s.rw;
    id_mem_read  = s.mr;
    id_mem_op    = s.mo;
    id_is_branch = s.br;
    pc_redirect  = s.redir;
    dmem_ready   = s.rdy;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit wr(ins_t s, int unsigned r);
    return s.v && s.rw && (s.rd == r) && (r != 0);
  endfunction

  function automatic bit hit(ins_t s);
    return (cur.u1 && wr(s, cur.rs1)) || (cur.u2 && wr(s, cur.rs2));
  endfunction

  function automatic int unsigned ex_fwd(int unsigned r);
    if (wr(m_mem, r)) return 2;
    if (wr(m_wb, r))  return 1;
    return 0;
  endfunction

  function automatic int unsigned br_fwd(int unsigned r);
    if (!cur.br) return 0;
    if (wr(m_ex, r) && !m_ex.mr)   return 3;
    if (wr(m_mem, r) && !m_mem.mr) return 2;
    if (wr(m_wb, r))               return 1;
    return 0;
  endfunction

  task automatic check_all();
    int unsigned e_sc, e_fc;
    e_freeze   = m_mem.v && m_mem.mo && !cur.rdy;
    e_stall    = !e_freeze && cur.v &&
                 ((m_ex.mr && hit(m_ex)) || (cur.br && hit(m_ex)) || (cur.br && m_mem.mr && hit(m_mem)));
    e_flush    = cur.redir && !e_stall && !e_freeze;
    e_pc_write = !e_freeze && !e_stall;
`ifdef HAZARD_PERF_CNT_EN
    e_sc = m_stall; e_fc = m_flush;
`else
    e_sc = 0; e_fc = 0;
`endif
    chk("forward_a",        32'(forward_a),        ex_fwd(m_ex.rs1));
    chk("forward_b",        32'(forward_b),        ex_fwd(m_ex.rs2));
    chk("forward_branch_a", 32'(forward_branch_a), br_fwd(cur.rs1));
    chk("forward_branch_b", 32'(forward_branch_b), br_fwd(cur.rs2));
    chk("pc_write",         32'(pc_write),         32'(e_pc_write));
    chk("ifid_write",       32'(ifid_write),       32'(e_pc_write));
    chk("ifid_flush",       32'(ifid_flush),       32'(e_flush));
    chk("ex_bubble",        32'(ex_bubble),        32'(e_stall));
    chk("pipe_freeze",      32'(pipe_freeze),      32'(e_freeze));
    chk("state_dbg",        32'(state_dbg),        32'(m_state));
    chk("stall_cnt",        stall_cnt,             e_sc);
    chk("flush_cnt",        flush_cnt,             e_fc);
  endtask

  task automatic model_update();
    ins_t n;
    n.v = cur.v; n.rd = cur.rd; n.rs1 = cur.rs1; n.rs2 = cur.rs2;
    n.rw = cur.rw; n.mr = cur.mr; n.mo = cur.mo;
    if (!e_freeze) begin
      m_wb  = m_mem;
      m_mem = m_ex;
      m_ex  = e_stall ? empty_ins : n;
    end
    m_state = e_freeze;
    if (e_stall && m_stall != 32'hffff_ffff) m_stall++;
    if (e_flush && m_flush != 32'hffff_ffff) m_flush++;
  endtask

  task automatic model_reset();
    m_ex = empty_ins; m_mem = empty_ins; m_wb = empty_ins;
    m_state = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  task automatic step(input id_t s);
    @(posedge clock);
    if (reset) model_update();
    @(negedge clock);
    cur = s;
    apply(s);
    #1 check_all();
  endtask

  task automatic reset_values(input string tag);
    chk({tag, "_pc_write"},    32'(pc_write),    1);
    chk({tag, "_ifid_write"},  32'(ifid_write),  1);
    chk({tag, "_ifid_flush"},  32'(ifid_flush),  0);
    chk({tag, "_ex_bubble"},   32'(ex_bubble),   0);
    chk({tag, "_pipe_freeze"}, 32'(pipe_freeze), 0);
    chk({tag, "_fwd"},         {24'd0, forward_a, forward_b, forward_branch_a, forward_branch_b}, 0);
    chk({tag, "_state"},       32'(state_dbg),   32'(RUN));
    chk({tag, "_counters"},    stall_cnt | flush_cnt, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    id_t r;
    int unsigned sc_before;
    empty_ins = '{v:0, rw:0, mr:0, mo:0, rd:0, rs1:0, rs2:0};
    model_reset();
    reset = 1'b0;
    cur = nop();
    apply(cur);
    // a redirect during reset must not leak onto ifid_flush
    pc_redirect = 1'b1;
    repeat (2) @(negedge clock);
    #1 reset_values("reset");
    @(negedge clock);
    apply(cur);
    reset = 1'b1;
    #1 check_all();

    // addi x5,x0,3; add x6,x5,x5; sub x7,x5,x1
    step(alui(5, 0));
    step(alu(6, 5, 5));
    step(alu(7, 5, 1));
    chk("t1_fwd_a_mem", 32'(forward_a), 2);
    chk("t1_fwd_b_mem", 32'(forward_b), 2);
    chk("t1_no_stall",  32'(ex_bubble), 0);
    step(nop());
    chk("t1_fwd_a_wb",  32'(forward_a), 1);
    step(nop()); step(nop());

    // lw x5,0(x1); add x6,x5,x2
    step(load(5, 1));
    step(alu(6, 5, 2));
    chk("t2_bubble",   32'(ex_bubble),  1);
    chk("t2_pc_hold",  32'(pc_write),   0);
    chk("t2_ifid_hold",32'(ifid_write), 0);
    step(alu(6, 5, 2));
    chk("t2_bubble_once", 32'(ex_bubble), 0);
    step(nop());
    chk("t2_fwd_a_wb", 32'(forward_a), 1);
    step(nop()); step(nop());

    // lw x5; beq x5,x0 taken
    step(load(5, 1));
    step(branch(5, 0, 1));
    chk("t3_stall1",   32'(ex_bubble),  1);
    chk("t3_no_flush1",32'(ifid_flush), 0);
    step(branch(5, 0, 1));
    chk("t3_stall2",   32'(ex_bubble),  1);
    chk("t3_no_flush2",32'(ifid_flush), 0);
    step(branch(5, 0, 1));
    chk("t3_fwd_br_wb",32'(forward_branch_a), 1);
    chk("t3_flush",    32'(ifid_flush), 1);
    chk("t3_pc_write", 32'(pc_write),   1);
    step(nop());
    chk("t3_flush_one",32'(ifid_flush), 0);
    step(nop()); step(nop());

    // add x0,x1,x2; add x3,x0,x0
    step(alu(0, 1, 2));
    step(alu(3, 0, 0));
    step(nop());
    chk("t4_x0_fwd", {30'd0, forward_a | forward_b}, 0);
    step(nop()); step(nop());

    // sw with dmem_ready low for three cycles
    step(store(1, 2));
    step(nop());
    sc_before = m_stall;
    r = nop(); r.rdy = 0;
    step(r);
    chk("t5_freeze1", 32'(pipe_freeze), 1);
    step(r);
    chk("t5_wait_state", 32'(state_dbg), 32'(MEM_WAIT));
    step(r);
    chk("t5_freeze3", 32'(pipe_freeze), 1);
    step(nop());
    chk("t5_released", 32'(pipe_freeze), 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("t5_stall_cnt_same", stall_cnt, sc_before);
`endif
    step(nop());
    chk("t5_run_state", 32'(state_dbg), 32'(RUN));

    // reset asserted while waiting on data memory
    step(store(1, 2));
    step(nop());
    r = nop(); r.rdy = 0;
    step(r);
    step(r);
    #2 reset = 1'b0;
    #1 reset_values("t6_reset");
    model_reset();
    cur = nop();
    apply(cur);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 check_all();
    step(nop());
    chk("t6_run_after", 32'(state_dbg), 32'(RUN));

    // random instruction streams, honouring the controller's hold/flush
    for (int i = 0; i < 400; i++) begin
      if (!e_pc_write) begin
        r = cur;
      end else if (e_flush) begin
        r = nop();
      end else begin
        case ($urandom_range(0, 5))
          0:       r = nop();
          1:       r = alu($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
          2:       r = alui($urandom_range(0, 3), $urandom_range(0, 3));
          3:       r = load($urandom_range(0, 3), $urandom_range(0, 3));
          4:       r = store($urandom_range(0, 3), $urandom_range(0, 3));
          default: r = branch($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        endcase
      end
      r.rdy = ($urandom_range(0, 4) != 0);
      step(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RISC-V pipeline datapath.
- Tracks destination and source register info of the instructions in EX, MEM and WB internally, and generates all forwarding selects.
- Generates the load-use and branch-in-ID stalls, the bubble into EX, the IF/ID flush on redirect, and a full-pipeline freeze while data memory is busy.
- Sits beside the datapath: it is fed by the ID-stage decode and the ID comparator, and drives the datapath's forwarding/enable inputs.

Parameters:
- REG_ADDR_W, 5, register index width.
- PERF_W, 32, width of the performance counters (optional feature only).

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_ADDR_W  ID source register 1.
- id_rs2  in  REG_ADDR_W  ID source register 2.
- id_rd  in  REG_ADDR_W  ID destination register.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- id_mem_op  in  1  ID instruction is a load or store.
- id_is_branch  in  1  ID instruction is a branch or JALR resolved in ID.
- pc_redirect  in  1  ID comparator selects a non-sequential PC.
- dmem_ready  in  1  data memory has completed the access in MEM.
- forward_a  out  2  EX operand A select: 00 none, 01 WB, 10 MEM.
- forward_b  out  2  EX operand B select: same encoding as forward_a.
- forward_branch_a  out  2  ID comparator A select: 00 regfile, 01 WB, 10 MEM, 11 EX.
- forward_branch_b  out  2  ID comparator B select: same encoding as forward_branch_a.
- pc_write  out  1  PC register enable.
- ifid_write  out  1  IF/ID register enable.
- ifid_flush  out  1  replace the IF/ID contents with a NOP.
- ex_bubble  out  1  load a NOP into ID/EX.
- pipe_freeze  out  1  hold all pipeline registers.
- stall_cnt  out  PERF_W  stall cycles (optional feature).
- flush_cnt  out  PERF_W  flushes (optional feature).

Behaviour:
- Reset (async, reset=0):
  - All stage valid bits cleared; FSM=RUN.
  - pc_write=1, ifid_write=1; ifid_flush=0, ex_bubble=0, pipe_freeze=0.
  - All forward selects = 00; counters = 0.
- Internal tracking: registered per-stage records {valid, rd, rs1, rs2, reg_write, mem_read, mem_op} for EX, MEM and WB.
  - Each clock: ID→EX, EX→MEM, MEM→WB.
  - The EX record loads as invalid when ex_bubble=1.
  - All records hold when pipe_freeze=1.
- A stage "writes r" only if valid && reg_write && rd==r && r!=0.
- EX forwarding (combinational, from the EX record):
  - MEM writes EX.rs → 10.
  - Else WB writes EX.rs → 01.
  - Else 00.
  - MEM has priority over WB.
- Branch forwarding (combinational, ID-side, only when id_is_branch):
  - EX writes rs and is not a load → 11.
  - Else MEM writes rs and is not a load → 10.
  - Else WB writes rs → 01.
  - Else 00.
- Stall conditions, evaluated combinationally in RUN (stall = any of):
  - Load-use: EX is a load and ID uses its rd.
  - Branch on EX: id_is_branch and EX writes a source used by ID.
  - Branch on a load in MEM: id_is_branch and a MEM load writes a source used by ID.
- On stall: pc_write=0, ifid_write=0, ex_bubble=1.
  - Load-use costs 1 cycle.
  - Branch after ALU op costs 1 cycle.
  - Branch after load costs 2 cycles.
- Redirect: pc_redirect && !stall && !pipe_freeze → ifid_flush=1 for one cycle; pc_write stays 1.
  - pc_redirect is ignored while stalled, because the comparator operands are stale.
- FSM:
  - RUN→MEM_WAIT when MEM valid && mem_op && !dmem_ready.
  - MEM_WAIT→RUN on dmem_ready.
  - In MEM_WAIT: pipe_freeze=1, pc_write=0, ifid_write=0, ex_bubble=0, ifid_flush=0.
  - pipe_freeze is also asserted combinationally in the first miss cycle in RUN.
- Priority: freeze > stall > redirect.
- Reset mid-stall or mid-MEM_WAIT: returns to RUN with empty stages; no residual bubble.
- Loads in WB forward through the WB path (01); no stall beyond those listed above.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments in each stall cycle; freeze cycles are not counted.
  - flush_cnt increments on each ifid_flush.
  - Both saturate at all-ones.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

Decomposition:
- Shared package hazard_pkg holds:
  - Typedef fwd_sel_e (FWD_NONE=00, FWD_WB=01, FWD_MEM=10, FWD_EX=11).
  - Typedef stage_rec_t (the stage record).
  - Typedef hz_state_e {RUN, MEM_WAIT}.
- One sub-module, fwd_select: a pure function of a stage-record triple and a source register, returning fwd_sel_e; instantiated four times.

Test Plan:
- addi x5,x0,3; add x6,x5,x5 → cycle the add is in EX: forward_a=10, forward_b=10; next cycle with the add's use of x5 from WB: select 01; no stall.
- lw x5,0(x1); add x6,x5,x2 → one cycle with ex_bubble=1, pc_write=0, ifid_write=0; then forward_a=01.
- lw x5; beq x5,x0 → two stall cycles; then forward_branch_a=01; pc_redirect honored only afterward, ifid_flush=1 for one cycle, flush_cnt=1.
- add x0,x1,x2; add x3,x0,x0 → all forward selects remain 00 (x0 never forwards).
- sw with dmem_ready low for 3 cycles → pipe_freeze=1 for 3 cycles, stage records unchanged; resumes on ready; stall_cnt unchanged.
- Assert reset during MEM_WAIT → outputs return to reset values immediately; FSM=RUN after release.
